// File: rtl/memory_arbiter.sv
// Arbitrates a single RAM port between an instruction fetch requester and a
// data requester. Data normally has priority, but a saturating counter of data
// grants taken while an instruction fetch waits forces the fetch through once
// the counter reaches STARVE_MAX. Every output is combinational from the
// registered grant state and the current inputs.
module memory_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   input  logic [1:0]  ramstate,
   input  logic [31:0] ramload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   output logic        iwait,
   output logic        dwait,
   output logic [31:0] iload,
   output logic [31:0] dload
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      DGNT = 2'b01,
      IGNT = 2'b10
   } state_t;

   localparam logic [1:0] RAM_ACCESS = 2'b10;
   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   state_t     state;
   state_t     next_state;
   logic [2:0] starve_cnt;
   logic       d_req;
   logic       d_done;
   logic       i_done;

   assign d_req  = dREN | dWEN;
   assign d_done = (state == DGNT) && (ramstate == RAM_ACCESS);
   assign i_done = (state == IGNT) && (ramstate == RAM_ACCESS);

   // Grant state register; reset drops any transaction in flight.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Starvation counter: counts data completions while a fetch waits, cleared when the fetch completes.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         starve_cnt <= 3'd0;
      end else if (i_done) begin
         starve_cnt <= 3'd0;
      end else if (d_done && iREN && (starve_cnt < STARVE_LIM)) begin
         starve_cnt <= starve_cnt + 3'd1;
      end
   end

   // Next-state selection and RAM-side drive for the current grant.
   always_comb begin
      next_state = state;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = 32'd0;
      ramstore   = 32'd0;
      unique case (state)
         IDLE: begin
            if (d_req) begin
               if (iREN && (starve_cnt == STARVE_LIM)) begin
                  next_state = IGNT;
               end else begin
                  next_state = DGNT;
               end
            end else if (iREN) begin
               next_state = IGNT;
            end
         end
         DGNT: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            if (!d_req || (ramstate == RAM_ACCESS)) begin
               next_state = IDLE;
            end
         end
         IGNT: begin
            ramaddr = iaddr;
            ramREN  = iREN;
            if (!iREN || (ramstate == RAM_ACCESS)) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Requester-side stall and return data.
   always_comb begin
      dwait = d_req & ~d_done;
      iwait = iREN & ~i_done;
      iload = ramload;
      dload = ramload;
   end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, max consecutive data grants while an instruction request waits.
REQ-002 CLK  in  1  system clock; all state updates on the rising edge.
REQ-003 nRST  in  1  asynchronous, active-low reset.
REQ-004 iREN  in  1  instruction fetch request.
REQ-005 iaddr  in  32  instruction word address.
REQ-006 dREN  in  1  data read request.
REQ-007 dWEN  in  1  data write request.
REQ-008 daddr  in  32  data address.
REQ-009 dstore  in  32  data write value.
REQ-010 ramstate  in  2  RAM status: FREE=00, BUSY=01, ACCESS=10, ERROR=11.
REQ-011 ramload  in  32  RAM read data.
REQ-012 ramREN  out  1  RAM read strobe.
REQ-013 ramWEN  out  1  RAM write strobe.
REQ-014 ramaddr  out  32  RAM address.
REQ-015 ramstore  out  32  RAM write data.
REQ-016 iwait  out  1  instruction side stalled.
REQ-017 dwait  out  1  data side stalled.
REQ-018 iload  out  32  instruction returned.
REQ-019 dload  out  32  data returned.

Function
REQ-020 FSM states SHALL be IDLE, DGNT and IGNT, held in one registered state variable.
REQ-021 In IDLE, ramREN=0, ramWEN=0, ramaddr=0 and ramstore=0.
REQ-022 In IDLE with dREN|dWEN=1, the next state SHALL be DGNT, unless iREN=1 and starve_cnt==STARVE_MAX, in which case it SHALL be IGNT.
REQ-023 In IDLE with only iREN=1, the next state SHALL be IGNT; with no request, it SHALL stay IDLE.
REQ-024 In DGNT: ramaddr=daddr and ramstore=dstore.
REQ-025 In DGNT: ramWEN=dWEN, and ramREN=dREN&~dWEN, so write wins when both are set.
REQ-026 In IGNT: ramaddr=iaddr, ramREN=iREN, ramWEN=0 and ramstore=0.
REQ-027 A grant SHALL NOT switch requester mid-transaction.
REQ-028 A grant SHALL hold while ramstate is FREE, BUSY or ERROR; ERROR is a retry, not a completion.
REQ-029 Completion: ramstate==ACCESS in DGNT or IGNT; the next state SHALL be IDLE, giving one idle cycle between transactions.
REQ-030 If the granted requester deasserts its request before completion, the next state SHALL be IDLE and the RAM strobes follow that request low in the same cycle.
REQ-031 dwait SHALL equal (dREN|dWEN) & ~(state==DGNT & ramstate==ACCESS).
REQ-032 iwait SHALL equal iREN & ~(state==IGNT & ramstate==ACCESS).
REQ-033 iload and dload SHALL both be driven combinationally from ramload every cycle.
REQ-034 starve_cnt is a 3-bit counter that saturates at STARVE_MAX.
REQ-035 starve_cnt SHALL increment on each DGNT completion while iREN=1, and clear on each IGNT completion.
REQ-036 Minimum latency: request in IDLE at cycle N, RAM strobes at N+1, earliest wait release at N+1 if ramstate==ACCESS.
REQ-037 All outputs SHALL be combinational functions of state and inputs; there are no output registers.

Reset
REQ-038 When nRST=0, state SHALL be IDLE and starve_cnt SHALL be 0 immediately, regardless of CLK.
REQ-039 During reset: ramREN=0, ramWEN=0, ramaddr=0 and ramstore=0.
REQ-040 During reset, iwait and dwait SHALL follow REQ-031 and REQ-032, i.e. 1 when requested.
REQ-041 Reset asserted mid-grant SHALL abandon the transaction with no completion signalled; after release, arbitration restarts from IDLE.

Verification
REQ-042 Scenario: iREN=1 with iaddr=0x40, ramstate=BUSY for 2 cycles then ACCESS with ramload=0x8C220004 -> ramREN=1 and ramaddr=0x40 from cycle 1, iwait=0 and iload=0x8C220004 in the ACCESS cycle, state returns to IDLE.
REQ-043 Scenario: iREN=1 and dWEN=1 together, daddr=0x100, dstore=0xDEADBEEF -> DGNT first with ramWEN=1, ramstore=0xDEADBEEF; IGNT after completion plus one IDLE cycle.
REQ-044 Scenario: iREN held at 1 with back-to-back dREN transactions and STARVE_MAX=4 -> exactly 4 data completions, then an IGNT grant, then starve_cnt=0.
REQ-045 Scenario: dREN=1 and dWEN=1 with daddr=0x200 -> ramWEN=1 and ramREN=0.
REQ-046 Scenario: ramstate=ERROR for 3 cycles in DGNT, then ACCESS -> dwait=1 throughout ERROR, grant held, completion on the ACCESS cycle.
REQ-047 Scenario: nRST pulsed low mid-IGNT -> state=IDLE and ramREN=0 immediately, no iwait release, normal arbitration after release.
